// File: rtl/y86_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : y86_pkg
//  Description : Shared Y86-64 constants (instruction codes, register IDs)
//                and a small register-ID helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package y86_pkg;

   // Instruction codes
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // Register IDs
   localparam logic [3:0] RRSP  = 4'h4;
   localparam logic [3:0] RNONE = 4'hF;

   // True when a register ID addresses real storage (below nreg, not RNONE)
   function automatic logic reg_present(input logic [3:0] id, input int nreg);
      return (id != RNONE) && ({28'd0, id} < nreg);
   endfunction

endpackage
`default_nettype wire

// File: rtl/y86_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : y86_regfile
//  Description : NREG x W program register file. Three combinational read
//                ports (A, B, debug), two write ports (E, M); port M wins on
//                an address collision. Asynchronous active-low clear.
//                Reads of ID RNONE (or any ID without storage) return 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module y86_regfile
   import y86_pkg::*;
#(
   parameter int NREG = 15,
   parameter int W    = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   // read ports
   input  logic [3:0]   rd_a_addr,
   output logic [W-1:0] rd_a_data,
   input  logic [3:0]   rd_b_addr,
   output logic [W-1:0] rd_b_data,
   input  logic [3:0]   rd_d_addr,
   output logic [W-1:0] rd_d_data,
   // write port E
   input  logic         we_e,
   input  logic [3:0]   wr_e_addr,
   input  logic [W-1:0] wr_e_data,
   // write port M (higher priority)
   input  logic         we_m,
   input  logic [3:0]   wr_m_addr,
   input  logic [W-1:0] wr_m_data
);

   logic [W-1:0] regs_q [NREG];
   logic [W-1:0] regs_d [NREG];

   // Next register state: E applied first so that M overrides it on a collision
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         regs_d[i] = regs_q[i];
      end
      if (we_e && reg_present(wr_e_addr, NREG)) begin
         regs_d[wr_e_addr] = wr_e_data;
      end
      if (we_m && reg_present(wr_m_addr, NREG)) begin
         regs_d[wr_m_addr] = wr_m_data;
      end
   end

   // Register storage with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= regs_d[i];
         end
      end
   end

   // Combinational reads from current state; absent IDs read as zero
   always_comb begin
      rd_a_data = '0;
      rd_b_data = '0;
      rd_d_data = '0;
      if (reg_present(rd_a_addr, NREG)) rd_a_data = regs_q[rd_a_addr];
      if (reg_present(rd_b_addr, NREG)) rd_b_data = regs_q[rd_b_addr];
      if (reg_present(rd_d_addr, NREG)) rd_d_data = regs_q[rd_d_addr];
   end

endmodule
`default_nettype wire

// File: rtl/decode_wb.sv
`default_nettype none
// ============================================================================
//  Module      : decode_wb
//  Description : Decode/writeback stage of the sequential Y86-64 processor.
//                Selects register sources/destinations from icode/rA/rB,
//                returns valA/valB combinationally and commits valE/valM
//                into the register file on the rising clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_wb
   import y86_pkg::*;
#(
   parameter int NREG = 15,
   parameter int W    = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [3:0]   icode,
   input  logic [3:0]   rA,
   input  logic [3:0]   rB,
   input  logic         inst_valid,
   input  logic         cnd,
   input  logic         wr_en,
   input  logic [W-1:0] valE,
   input  logic [W-1:0] valM,
   output logic [3:0]   srcA,
   output logic [3:0]   srcB,
   output logic [3:0]   dstE,
   output logic [3:0]   dstM,
   output logic [W-1:0] valA,
   output logic [W-1:0] valB,
   input  logic [3:0]   dbg_sel,
   output logic [W-1:0] dbg_val
);

   logic commit;

   // Source/destination selection; unlisted icodes select nothing
   always_comb begin
      srcA = RNONE;
      srcB = RNONE;
      dstE = RNONE;
      dstM = RNONE;
      unique case (icode)
         IRRMOVQ: begin
            srcA = rA;
            // cmovxx only writes back when the condition holds
            dstE = cnd ? rB : RNONE;
         end
         IIRMOVQ: dstE = rB;
         IRMMOVQ: begin
            srcA = rA;
            srcB = rB;
         end
         IMRMOVQ: begin
            srcB = rB;
            dstM = rA;
         end
         IOPQ: begin
            srcA = rA;
            srcB = rB;
            dstE = rB;
         end
         ICALL: begin
            srcB = RRSP;
            dstE = RRSP;
         end
         IRET: begin
            srcA = RRSP;
            srcB = RRSP;
            dstE = RRSP;
         end
         IPUSHQ: begin
            srcA = rA;
            srcB = RRSP;
            dstE = RRSP;
         end
         IPOPQ: begin
            srcA = RRSP;
            srcB = RRSP;
            dstE = RRSP;
            dstM = rA;
         end
         default: ;
      endcase
   end

   // Writes happen only for a valid instruction that is not stalled
   always_comb begin
      commit = wr_en & inst_valid;
   end

   y86_regfile #(
      .NREG (NREG),
      .W    (W)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_a_addr (srcA),
      .rd_a_data (valA),
      .rd_b_addr (srcB),
      .rd_b_data (valB),
      .rd_d_addr (dbg_sel),
      .rd_d_data (dbg_val),
      .we_e      (commit),
      .wr_e_addr (dstE),
      .wr_e_data (valE),
      .we_m      (commit),
      .wr_m_addr (dstM),
      .wr_m_data (valM)
   );

endmodule
`default_nettype wire
